// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, default latencies and hazard helpers
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int STALL_CNT_W     = 16;

    function automatic int imax(input int a, input int b);
        return a > b ? a : b;
    endfunction

    // A producer register matches when it is non-zero and one of the used sources names it
    function automatic logic src_match(
        input logic [4:0] dst,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rs,
        input logic       use_rt
    );
        return (dst != 5'd0) && ((use_rs && rs == dst) || (use_rt && rt == dst));
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// md_busy_timer: load/decrement counter tracking remaining multiply/divide latency
module md_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic start,
    input  logic div,
    output logic busy
);
    localparam int W = $clog2(imax(MULT_CYCLES, DIV_CYCLES) + 1);

    logic [W-1:0] cnt;

    // A new issue reloads the counter; otherwise it drains towards zero
    always_ff @(posedge clk)
        if (reset) cnt <= '0;
        else if (en && start) cnt <= div ? W'(DIV_CYCLES) : W'(MULT_CYCLES);
        else if (en && cnt != '0) cnt <= cnt - 1'b1;

    assign busy = cnt != '0;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, stall/flush control, post-reset init and stall statistics
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int INIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             rsD,
    input  logic [4:0]             rtD,
    input  logic                   use_rsD,
    input  logic                   use_rtD,
    input  logic                   branchD,
    input  logic                   md_startD,
    input  logic                   md_divD,
    input  logic                   md_readD,
    input  logic [4:0]             dstE,
    input  logic                   regwriteE,
    input  logic                   mem_readE,
    input  logic [4:0]             dstM,
    input  logic                   mem_readM,
    output logic                   stallF,
    output logic                   stallD,
    output logic                   flushD,
    output logic                   flushE,
    output logic                   md_busy,
    output logic [STALL_CNT_W-1:0] stall_count
);
    localparam int ICW = INIT_CYCLES > 1 ? $clog2(INIT_CYCLES) : 1;

    state_t         state, state_nxt;
    logic [ICW-1:0] init_cnt, init_cnt_nxt;
    logic           run, init_done, timer_busy;
    logic           lw_hz, br_hz, md_hz, hz;

    assign run       = !reset && state == ST_RUN;
    assign init_done = int'(init_cnt) + 1 >= INIT_CYCLES;
    assign md_busy   = run && timer_busy;

    assign lw_hz = mem_readE && src_match(dstE, rsD, rtD, use_rsD, use_rtD);
    assign br_hz = branchD && ((regwriteE && src_match(dstE, rsD, rtD, use_rsD, use_rtD))
                            || (mem_readM && src_match(dstM, rsD, rtD, use_rsD, use_rtD)));
    assign md_hz = (md_startD || md_readD) && md_busy;
    assign hz    = lw_hz || br_hz || md_hz;

    md_busy_timer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .en   (run),
        .start(md_startD && !hz),
        .div  (md_divD),
        .busy (timer_busy)
    );

    // Init FSM state and cycle counter
    always_ff @(posedge clk)
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end

    // Init sequencing plus stall/flush decode; bubbles are held until the pipe is clean
    always_comb begin
        state_nxt    = (state == ST_INIT && init_done) ? ST_RUN : state;
        init_cnt_nxt = (state == ST_INIT && !init_done) ? init_cnt + 1'b1 : init_cnt;
        stallF       = run ? hz : 1'b1;
        stallD       = run ? hz : 1'b1;
        flushE       = run ? hz : 1'b1;
        flushD       = !run;
    end

    // Saturating count of stalled RUN cycles
    always_ff @(posedge clk)
        if (reset) stall_count <= '0;
        else if (run && hz && stall_count != '1) stall_count <= stall_count + 1'b1;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboarded random and directed checks against a behavioural model
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b1;
    logic        reset = 1'b1;
    logic [4:0]  rsD, rtD, dstE, dstM;
    logic        use_rsD, use_rtD, branchD, md_startD, md_divD, md_readD;
    logic        regwriteE, mem_readE, mem_readM;
    logic        stallF, stallD, flushD, flushE, md_busy;
    logic [15:0] stall_count;

    typedef struct packed {
        logic        chk_sc;
        logic        stall;
        logic        flushD;
        logic        busy;
        logic [15:0] sc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   passed = 0;

    bit m_run = 0;
    bit m_known = 0;
    int m_init = 0;
    int m_md = 0;
    int m_sc = 0;

    pipe_hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rsD        (rsD),
        .rtD        (rtD),
        .use_rsD    (use_rsD),
        .use_rtD    (use_rtD),
        .branchD    (branchD),
        .md_startD  (md_startD),
        .md_divD    (md_divD),
        .md_readD   (md_readD),
        .dstE       (dstE),
        .regwriteE  (regwriteE),
        .mem_readE  (mem_readE),
        .dstM       (dstM),
        .mem_readM  (mem_readM),
        .stallF     (stallF),
        .stallD     (stallD),
        .flushD     (flushD),
        .flushE     (flushE),
        .md_busy    (md_busy),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic bit src(input logic [4:0] r);
        return r != 0 && ((use_rsD && rsD == r) || (use_rtD && rtD == r));
    endfunction

    // Predict this cycle's outputs, queue them, advance the model, then move to the next cycle
    task automatic step();
        exp_t e;
        bit live, busy, hz;
        live = !reset && m_run;
        busy = live && m_md > 0;
        hz = live && ((mem_readE && src(dstE))
                   || (branchD && ((regwriteE && src(dstE)) || (mem_readM && src(dstM))))
                   || ((md_startD || md_readD) && busy));
        e.chk_sc = m_known;
        e.stall = !live || hz;
        e.flushD = !live;
        e.busy = busy;
        e.sc = 16'(m_sc);
        q.push_back(e);
        if (reset) begin
            m_run = 0; m_init = 0; m_md = 0; m_sc = 0; m_known = 1;
        end else if (!m_run) begin
            m_init++;
            if (m_init >= 2) m_run = 1;
        end else begin
            if (md_startD && !hz) m_md = md_divD ? 10 : 5;
            else if (m_md > 0) m_md--;
            if (hz && m_sc < 65535) m_sc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        reset = 0; rsD = 0; rtD = 0; dstE = 0; dstM = 0;
        use_rsD = 0; use_rtD = 0; branchD = 0; md_startD = 0; md_divD = 0; md_readD = 0;
        regwriteE = 0; mem_readE = 0; mem_readM = 0;
    endtask

    task automatic rnd();
        reset = $urandom_range(0, 60) == 0;
        rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
        dstE = 5'($urandom_range(0, 3)); dstM = 5'($urandom_range(0, 3));
        use_rsD = 1'($urandom); use_rtD = 1'($urandom); branchD = 1'($urandom);
        md_startD = $urandom_range(0, 5) == 0; md_divD = 1'($urandom);
        md_readD = $urandom_range(0, 3) == 0;
        regwriteE = 1'($urandom); mem_readE = 1'($urandom); mem_readM = 1'($urandom);
    endtask

    // Monitor: every cycle's outputs are compared against the oldest prediction
    always @(negedge clk)
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stallF", int'(stallF), int'(e.stall));
            chk("stallD", int'(stallD), int'(e.stall));
            chk("flushE", int'(flushE), int'(e.stall));
            chk("flushD", int'(flushD), int'(e.flushD));
            chk("md_busy", int'(md_busy), int'(e.busy));
            if (e.chk_sc) chk("stall_count", int'(stall_count), int'(e.sc));
        end

    initial begin
        int n;
        clr();
        reset = 1;
        repeat (3) step();
        clr();
        repeat (3) step();
        mem_readE = 1; dstE = 8; use_rsD = 1; rsD = 8;
        step();
        dstE = 0; rsD = 0;
        step();
        clr();
        md_startD = 1; md_divD = 1;
        step();
        clr();
        md_readD = 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!stallD) break;
            n++;
            step();
        end
        chk("mflo_stall_cycles", n, 10);
        step();
        clr();
        branchD = 1; rtD = 9; use_rtD = 1; mem_readM = 1; dstM = 9;
        step();
        mem_readM = 0; regwriteE = 1; dstE = 9;
        step();
        clr();
        md_startD = 1;
        step();
        clr();
        repeat (2) step();
        reset = 1;
        step();
        clr();
        repeat (4) step();
        for (int i = 0; i < 3000; i++) begin
            rnd();
            step();
        end
        clr();
        reset = 1;
        step();
        clr();
        repeat (3) step();
        mem_readE = 1; dstE = 8; use_rsD = 1; rsD = 8;
        repeat (70000) step();
        clr();
        repeat (2) step();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
